multi_channel_averager: RTL
===========================

// Module: multi_channel_averager
// PURPOSE
//  Per-channel averager for the accelerometer sample path (e.g. X/Y/Z packed on one bus).
//  Averages 2^LOG2_N signed samples per channel, selectable rounding, in one of two modes:
//   - MODE=0 block: one result per N samples.
//   - MODE=1 sliding window: one result per sample once the window is full.
//  Sits between the sample memory/sensor reader and the display/UART formatting stage.
// PARAMETERS
//  DATA_WIDTH  12  signed sample width per channel (2..24)
//  CHANNELS    3   number of channels packed on the data bus (>=1)
//  LOG2_N      4   window/block length N = 2^LOG2_N (0..8)
//  MODE        0   0 = block average, 1 = sliding-window average
//  ROUND       1   1 = round half toward +inf, 0 = truncate toward -inf
// PORTS
//  clk           in   1                    system clock, all logic on rising edge
//  reset         in   1                    synchronous, active-low reset (0 = reset)
//  i_Sample_Data in   CHANNELS*DATA_WIDTH  ch k at [k*DATA_WIDTH +: DATA_WIDTH], signed
//  i_Sample_Valid in  1                    one sample per channel accepted per high cycle
//  i_Clear       in   1                    synchronous restart of accumulation
//  o_AVG_Average out  CHANNELS*DATA_WIDTH  per-channel signed average, same packing
//  o_AVG_Ready   out  1                    1-cycle pulse: o_AVG_Average updated this cycle
//  o_AVG_Count   out  LOG2_N+1             samples in current block (MODE0) / window fill (MODE1)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): accumulators, count, write pointer, fill, o_AVG_Average,
//    o_AVG_Ready, o_AVG_Count all 0. Reset overrides i_Clear and i_Sample_Valid.
//  - Accumulator per channel: signed DATA_WIDTH+LOG2_N bits; inputs sign-extended; no overflow.
//  - Result = (sum + R) >>> LOG2_N, truncated to DATA_WIDTH.
//    R = 2^(LOG2_N-1) if ROUND=1 and LOG2_N>0, else 0.
//    Rounding is computed at DATA_WIDTH+LOG2_N+1 bits so that sum+R cannot wrap.
//    LOG2_N=0: output = input.
//  - MODE0: each valid adds the sample and increments the count.
//    On the valid that makes count N:
//     - result is computed from sum including that sample
//     - registered into o_AVG_Average, o_AVG_Ready=1 on the following cycle
//     - accumulator and count return to 0 in the same edge
//    Blocks are back-to-back; no dead cycle; valid on the cycle after a completion is sample 1.
//  - MODE1: per-channel circular buffer, depth N, shared write pointer wptr (wraps N-1 -> 0).
//    On valid:
//     - oldest = buf[wptr] if fill==N, else 0
//     - acc <= acc + new - oldest; buf[wptr] <= new; wptr++; fill saturates at N
//     - when fill (after update) == N, result from the updated acc is registered and o_AVG_Ready
//       pulses next cycle, i.e. for the Nth and every later sample
//    Buffer contents need no reset; fill gating makes stale entries read as 0.
//  - Latency: 1 clock from the accepting valid edge to o_AVG_Ready/o_AVG_Average.
//    o_AVG_Ready is never high two cycles for one sample.
//  - o_AVG_Average holds its value between pulses. It is not changed by i_Clear.
//  - i_Clear=1: acc, count, fill, wptr <= 0; o_AVG_Ready <= 0.
//    A sample valid in the same cycle is discarded.
//  - i_Sample_Valid low: all state holds.
//  - Channels are independent; valid/count/pointers are shared.
//  - Illegal parameters (LOG2_N>8, CHANNELS<1, MODE/ROUND not 0/1): $fatal at elaboration.
// TESTING
//  T1 MODE0 default: 16 valids, ch0=100 -> Ready one cycle after 16th valid, ch0 avg=100, Count=0.
//  T2 Rounding: eight -1 + eight 0 (sum -8):
//     - ROUND=1 -> avg 0
//     - ROUND=0 -> avg -1
//     - sum -15 -> -1 both
//  T3 Extremes: 16x -2048 -> -2048; 16x 2047 -> 2047 (ROUND=1, no wrap); ch0/ch1/ch2 =
//     100/-50/0 -> same values per lane.
//  T4 MODE1 LOG2_N=2, ROUND=1: samples 4,8,12,16,20,24 ->
//     - no Ready for first 3
//     - then avg 10, 14, 18 on consecutive pulses
//  T5 i_Clear after 5 samples (and once coincident with a valid), then 16x 7 ->
//     exactly one pulse, avg 7; prior average held during clear.
//  T6 reset=0 mid-block with valid high -> all outputs 0 next edge; next 16 samples of 9 -> avg 9.
//     Gapped valids (idle cycles between) give identical results.

Source files
------------

// File: rtl/multi_channel_averager.sv
// Averages 2^LOG2_N signed samples per packed channel, in block mode (MODE=0) or sliding-window mode (MODE=1).
// Result and ready pulse are registered one clock after the accepting valid; there is no backpressure, and i_Clear drops any coincident sample.
module multi_channel_averager #(
  parameter int DATA_WIDTH = 12,
  parameter int CHANNELS   = 3,
  parameter int LOG2_N     = 4,
  parameter int MODE       = 0,
  parameter int ROUND      = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_Sample_Data,
  input  logic                           i_Sample_Valid,
  input  logic                           i_Clear,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_AVG_Average,
  output logic                           o_AVG_Ready,
  output logic [LOG2_N:0]                o_AVG_Count
);

  localparam int N    = 1 << LOG2_N;
  localparam int AW   = DATA_WIDTH + LOG2_N;
  localparam int PW   = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int RVAL = (ROUND == 1) ? N / 2 : 0;
  localparam logic [LOG2_N:0] N_CNT = (LOG2_N+1)'(N);

  if (LOG2_N < 0 || LOG2_N > 8 || CHANNELS < 1 || DATA_WIDTH < 2 || DATA_WIDTH > 24 ||
      (MODE != 0 && MODE != 1) || (ROUND != 0 && ROUND != 1)) begin : g_param_check
    $fatal(1, "multi_channel_averager: illegal parameter combination");
  end

  logic [LOG2_N:0] cnt;
  logic [LOG2_N:0] cnt_inc;
  logic            at_full;
  logic            full_now;
  logic            accept;
  logic signed [DATA_WIDTH-1:0] oldest [CHANNELS];

  assign accept   = i_Sample_Valid && !i_Clear;
  assign cnt_inc  = cnt + (LOG2_N+1)'(1);
  assign at_full  = (cnt == N_CNT);
  // Block mode completes on exactly the Nth sample; window mode on every sample once full.
  assign full_now = (MODE == 0) ? (cnt_inc == N_CNT) : (at_full || cnt_inc == N_CNT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      o_AVG_Ready <= 1'b0;
    end else if (i_Clear) begin
      cnt         <= '0;
      o_AVG_Ready <= 1'b0;
    end else begin
      o_AVG_Ready <= i_Sample_Valid && full_now;
      if (i_Sample_Valid) begin
        if (MODE == 0) cnt <= full_now ? '0 : cnt_inc;
        else           cnt <= at_full ? cnt : cnt_inc;
      end
    end
  end

  assign o_AVG_Count = cnt;

  if (MODE == 1) begin : g_window
    logic [PW-1:0] wptr;

    always_ff @(posedge clk) begin
      if (!reset || i_Clear)  wptr <= '0;
      else if (i_Sample_Valid) wptr <= (wptr == PW'(N-1)) ? '0 : wptr + PW'(1);
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_buf
      logic signed [DATA_WIDTH-1:0] mem [N];

      // Stale entries are harmless: the fill gate masks them until the window is full.
      always_ff @(posedge clk) begin
        if (reset && accept) mem[wptr] <= i_Sample_Data[k*DATA_WIDTH +: DATA_WIDTH];
      end

      assign oldest[k] = at_full ? mem[wptr] : '0;
    end
  end else begin : g_block
    for (genvar k = 0; k < CHANNELS; k++) begin : g_zero
      assign oldest[k] = '0;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] sample;
    logic signed [AW-1:0]         acc;
    logic signed [AW-1:0]         acc_next;
    logic signed [AW:0]           rounded;
    logic signed [DATA_WIDTH-1:0] avg_q;

    assign sample   = i_Sample_Data[k*DATA_WIDTH +: DATA_WIDTH];
    assign acc_next = acc + AW'(sample) - AW'(oldest[k]);
    // One extra bit so adding the rounding constant to a maximal sum cannot wrap.
    assign rounded  = (AW+1)'(acc_next) + (AW+1)'(RVAL);

    always_ff @(posedge clk) begin
      if (!reset) begin
        acc   <= '0;
        avg_q <= '0;
      end else if (i_Clear) begin
        acc   <= '0;
      end else if (i_Sample_Valid) begin
        acc <= (MODE == 0 && full_now) ? '0 : acc_next;
        if (full_now) avg_q <= DATA_WIDTH'(rounded >>> LOG2_N);
      end
    end

    assign o_AVG_Average[k*DATA_WIDTH +: DATA_WIDTH] = avg_q;
  end

endmodule
